// File: rtl/frame_align_ctrl.sv
// rtl/frame_align_ctrl.sv - frame-lane bit/word alignment controller for the ADC DDR receive path
// Searches every bit position via lane bitslip toggles plus word-boundary skips.
module frame_align_ctrl #(
  parameter int                    FRAME_BITS    = 8,
  parameter logic [FRAME_BITS-1:0] FRAME_PATTERN = 8'hF0,
  parameter int                    SETTLE_CYCLES = 6,
  parameter int                    MATCH_WORDS   = 4,
  parameter int                    MISS_WORDS    = 2
) (
  input  logic                          dco_clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          frame_rise,
  input  logic                          frame_fall,
  output logic                          bitslip_pulse,
  output logic                          slip_state,
  output logic                          word_strobe,
  output logic                          locked,
  output logic                          align_err,
  output logic [$clog2(FRAME_BITS)-1:0] attempt
);

  localparam int WORDS = FRAME_BITS / 2;
  localparam int AW    = $clog2(FRAME_BITS);
  localparam int PW    = $clog2(WORDS);
  localparam int SW    = $clog2(SETTLE_CYCLES);
  localparam int MW    = $clog2(MATCH_WORDS + 1);
  localparam int XW    = $clog2(MISS_WORDS + 1);

  localparam logic [PW-1:0] PHASE_LAST  = PW'(WORDS - 1);
  localparam logic [AW-1:0] ATT_LAST    = AW'(FRAME_BITS - 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_WORDS - 1);
  localparam logic [XW-1:0] MISS_LAST   = XW'(MISS_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t state;

  // Only the bits still needed to form the next word are kept.
  logic [FRAME_BITS-3:0] sr;
  logic [FRAME_BITS-1:0] sr_next;
  logic [PW-1:0]         word_phase;
  logic [PW-1:0]         phase_next;
  logic                  word_skip;
  logic [SW-1:0]         settle_cnt;
  logic [MW-1:0]         match_cnt;
  logic [XW-1:0]         miss_cnt;
  logic                  word_match;

  assign sr_next    = {sr, frame_rise, frame_fall};
  assign word_match = (sr_next == FRAME_PATTERN);

  // A skip cycle holds the phase, pushing the word boundary two bits later.
  always_comb begin
    phase_next = word_phase;
    if (!word_skip) begin
      phase_next = (word_phase == PHASE_LAST) ? '0 : word_phase + 1'b1;
    end
  end

  always_ff @(posedge dco_clk) begin
    if (rst) begin
      state         <= S_IDLE;
      sr            <= '0;
      word_phase    <= '0;
      word_strobe   <= 1'b0;
      word_skip     <= 1'b0;
      bitslip_pulse <= 1'b0;
      slip_state    <= 1'b0;
      locked        <= 1'b0;
      align_err     <= 1'b0;
      attempt       <= '0;
      settle_cnt    <= '0;
      match_cnt     <= '0;
      miss_cnt      <= '0;
    end else begin
      sr            <= sr_next[FRAME_BITS-3:0];
      word_phase    <= phase_next;
      word_strobe   <= (phase_next == PHASE_LAST);
      word_skip     <= 1'b0;
      bitslip_pulse <= 1'b0;

      if (start) begin
        state      <= S_SETTLE;
        attempt    <= '0;
        match_cnt  <= '0;
        miss_cnt   <= '0;
        locked     <= 1'b0;
        align_err  <= 1'b0;
        settle_cnt <= SETTLE_LOAD;
      end else begin
        case (state)
          S_IDLE: ;

          S_SETTLE: begin
            if (settle_cnt == '0) begin
              state     <= S_CHECK;
              match_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt - 1'b1;
            end
          end

          S_CHECK: begin
            if (word_strobe) begin
              if (word_match) begin
                match_cnt <= match_cnt + 1'b1;
                if (match_cnt == MATCH_LAST) begin
                  state    <= S_LOCKED;
                  locked   <= 1'b1;
                  miss_cnt <= '0;
                end
              end else if (attempt == ATT_LAST) begin
                state     <= S_FAIL;
                align_err <= 1'b1;
              end else begin
                // Undoing a lane delay costs one bit, so the boundary skips two.
                attempt       <= attempt + 1'b1;
                bitslip_pulse <= 1'b1;
                slip_state    <= ~slip_state;
                word_skip     <= slip_state;
                settle_cnt    <= SETTLE_LOAD;
                state         <= S_SETTLE;
              end
            end
          end

          S_LOCKED: begin
            if (word_strobe) begin
              if (word_match) begin
                miss_cnt <= '0;
              end else if (miss_cnt == MISS_LAST) begin
                state     <= S_CHECK;
                locked    <= 1'b0;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end
          end

          S_FAIL: ;

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_align_ctrl.sv
// tb/tb_frame_align_ctrl.sv - self-checking bench for frame_align_ctrl with a lane_bitslip loop model
// Bit position after N pulses since reset is N; lock expected where that meets the source rotation.
module tb_frame_align_ctrl;

  localparam int SETTLE = 6;

  logic       dco_clk = 1'b0;
  logic       rst, start, frame_rise, frame_fall;
  logic       bitslip_pulse, slip_state, word_strobe, locked, align_err;
  logic [2:0] attempt;

  int   tests = 0;
  int   fails = 0;
  int   cyc, rot, inv_from, inv_to;
  int   pulses_total, pulses_since, skips, last_pulse;
  bit   zero_src, lane_st, chk_win;
  logic [7:0] win;

  frame_align_ctrl dut (
    .dco_clk      (dco_clk),
    .rst          (rst),
    .start        (start),
    .frame_rise   (frame_rise),
    .frame_fall   (frame_fall),
    .bitslip_pulse(bitslip_pulse),
    .slip_state   (slip_state),
    .word_strobe  (word_strobe),
    .locked       (locked),
    .align_err    (align_err),
    .attempt      (attempt)
  );

  always #5 dco_clk = ~dco_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Source bit i of the frame stream, MSB of the pattern first in time.
  function automatic logic src_bit(input int i);
    logic [7:0] pat;
    int idx;
    pat = 8'hF0;
    if (zero_src) return 1'b0;
    idx = (i + rot + 64) % 8;
    return pat[7-idx];
  endfunction

  // lane_bitslip model: unslipped path lags two bits, slipped path lags one.
  task automatic drive();
    logic r, f;
    if (!lane_st) begin
      r = src_bit(2*cyc - 2);
      f = src_bit(2*cyc - 1);
    end else begin
      r = src_bit(2*cyc - 1);
      f = src_bit(2*cyc);
    end
    if (cyc >= inv_from && cyc <= inv_to) begin
      r = ~r;
      f = ~f;
    end
    frame_rise = r;
    frame_fall = f;
  endtask

  task automatic tick();
    logic p, s;
    p   = bitslip_pulse;
    s   = word_strobe;
    win = {win[5:0], frame_rise, frame_fall};
    if (chk_win && s) check("locked_word", win, 8'hF0);
    @(posedge dco_clk);
    #1;
    if (p === 1'b1) begin
      check("pulse_spacing", (cyc - last_pulse) >= SETTLE + 1, 1);
      if (lane_st) skips++;
      lane_st = ~lane_st;
      pulses_total++;
      pulses_since++;
      last_pulse = cyc;
    end
    cyc++;
    drive();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    tick();
    tick();
    rst          = 1'b0;
    cyc          = 0;
    lane_st      = 1'b0;
    pulses_total = 0;
    pulses_since = 0;
    skips        = 0;
    last_pulse   = -100;
    inv_from     = -10;
    inv_to       = -10;
    win          = '0;
    chk_win      = 1'b0;
    drive();
  endtask

  task automatic do_start();
    start        = 1'b1;
    pulses_since = 0;
    skips        = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(locked === 1'b1 || align_err === 1'b1) && n < 600) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, n < 600, 1);
  endtask

  task automatic wait_strobe();
    int n = 0;
    while (word_strobe !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    check("strobe_found", n < 12, 1);
  endtask

  task automatic lock_run(input int r, input string tag);
    int exp_att;
    rot = r;
    do_reset();
    repeat ($urandom_range(0, 7)) tick();
    exp_att = (2 - rot + 8) % 8;
    do_start();
    wait_done(tag);
    check({tag, "_locked"}, locked, 1);
    check({tag, "_attempt"}, attempt, exp_att);
    check({tag, "_pulses"}, pulses_since, exp_att);
    check({tag, "_skips"}, skips, exp_att / 2);
    check({tag, "_slip"}, slip_state, exp_att % 2);
  endtask

  initial begin
    int c;
    rst          = 1'b1;
    start        = 1'b0;
    zero_src     = 1'b0;
    rot          = 2;
    cyc          = 0;
    lane_st      = 1'b0;
    inv_from     = -10;
    inv_to       = -10;
    last_pulse   = -100;
    pulses_total = 0;
    pulses_since = 0;
    skips        = 0;
    win          = '0;
    chk_win      = 1'b0;
    drive();

    // Reset and idle: quiet outputs, strobe every fourth cycle from cycle 3.
    do_reset();
    for (int i = 0; i < 50; i++) begin
      check("idle_strobe", word_strobe, (cyc % 4) == 3);
      check("idle_status", {bitslip_pulse, slip_state, locked, align_err, attempt}, 0);
      tick();
    end

    lock_run(2, "aligned");

    // Offset of three bits, then lock-loss behaviour at that position.
    lock_run(7, "offset3");
    chk_win = 1'b1;
    repeat (40) tick();
    chk_win = 1'b0;
    check("offset3_hold", locked, 1);

    wait_strobe();
    c        = cyc;
    inv_from = c + 1;
    inv_to   = c + 4;
    repeat (9) tick();
    check("one_miss_locked", locked, 1);

    wait_strobe();
    c        = cyc;
    inv_from = c + 1;
    inv_to   = c + 8;
    repeat (8) tick();
    check("two_miss_before", locked, 1);
    tick();
    check("two_miss_after", locked, 0);
    wait_done("relock");
    check("relock_locked", locked, 1);
    check("relock_attempt", attempt, 3);
    check("relock_pulses", pulses_since, 3);

    // No pattern anywhere: every position fails.
    zero_src = 1'b1;
    do_reset();
    do_start();
    wait_done("nopat");
    check("nopat_err", align_err, 1);
    check("nopat_locked", locked, 0);
    check("nopat_attempt", attempt, 7);
    check("nopat_pulses", pulses_since, 7);
    check("nopat_slip", slip_state, 1);
    do_start();
    check("nopat_restart_err", align_err, 0);
    check("nopat_restart_att", attempt, 0);
    check("nopat_restart_slip", slip_state, 1);
    for (int i = 0; i < SETTLE; i++) begin
      check("nopat_settle_quiet", bitslip_pulse, 0);
      tick();
    end
    zero_src = 1'b0;

    // Restart during the settle that follows the second pulse.
    rot = 5;
    do_reset();
    do_start();
    c = 0;
    while (pulses_since < 2 && c < 300) begin
      tick();
      c++;
    end
    check("restart_reach2", pulses_since, 2);
    tick();
    do_start();
    check("restart_attempt", attempt, 0);
    check("restart_nopulse", bitslip_pulse, 0);
    for (int i = 0; i < SETTLE; i++) begin
      check("restart_settle_quiet", bitslip_pulse, 0);
      tick();
    end
    wait_done("restart");
    check("restart_locked", locked, 1);
    check("restart_final_att", attempt, 3);
    check("restart_final_pulses", pulses_since, 3);
    check("restart_slip", slip_state, pulses_total % 2);

    // Random source rotations.
    for (int k = 0; k < 4; k++) begin
      lock_run($urandom_range(0, 7), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
